// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - address map, region decode and FSM encodings for the MIO responder
package mio_pkg;

   localparam logic [31:0] LED_ADDR = 32'hF000_0000;
   localparam logic [31:0] SW_ADDR  = 32'hF000_0004;
   localparam logic [31:0] CNT_ADDR = 32'hF000_0008;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_LED,
      REG_SW,
      REG_CNT,
      REG_NONE
   } region_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RAM_WR,
      ST_RAM_RD,
      ST_PERIPH,
      ST_DONE
   } state_t;

endpackage

// File: rtl/mio_periph_regs.sv
// rtl/mio_periph_regs.sv - LED register, switch synchronizer and free-running counter
module mio_periph_regs
   import mio_pkg::*;
#(
   parameter int SW_W = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wr_en,
   input  region_t         sel,
   input  logic [31:0]     wdata,
   input  logic [SW_W-1:0] sw_in,
   output logic [31:0]     rdata,
   output logic [31:0]     led_out
);

   logic [SW_W-1:0] sw_meta;
   logic [SW_W-1:0] sw_sync;
   logic [31:0]     cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_out <= '0;
         sw_meta <= '0;
         sw_sync <= '0;
         cnt     <= '0;
      end else begin
         sw_meta <= sw_in;
         sw_sync <= sw_meta;
         if (wr_en && sel == REG_LED)
            led_out <= wdata;
         // a CPU load wins over the free-running increment
         if (wr_en && sel == REG_CNT)
            cnt <= wdata;
         else
            cnt <= cnt + 32'd1;
      end
   end

   always_comb begin
      rdata = '0;
      case (sel)
         REG_LED: rdata = led_out;
         REG_SW:  rdata[SW_W-1:0] = sw_sync;
         REG_CNT: rdata = cnt;
         default: rdata = '0;
      endcase
   end

endmodule

// File: rtl/mio_bus_responder.sv
// rtl/mio_bus_responder.sv - CPU memory/IO target: decodes RAM vs peripherals, inserts wait states, drives MIO_ready
module mio_bus_responder
   import mio_pkg::*;
#(
   parameter int RAM_AW      = 14,
   parameter int RAM_LATENCY = 2,
   parameter int SW_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mem_req,
   input  logic              mem_w,
   input  logic [31:0]       M_addr,
   input  logic [31:0]       data_out,
   output logic [31:0]       data2CPU,
   output logic              MIO_ready,
   output logic              bus_err,
   output logic              ram_en,
   output logic              ram_we,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [31:0]       ram_din,
   input  logic [31:0]       ram_dout,
   input  logic [SW_W-1:0]   sw_in,
   output logic [31:0]       led_out
);

   state_t            state, state_nx;
   region_t           region_dec, region_q;
   logic              w_q;
   logic [RAM_AW-1:0] addr_q;
   logic [31:0]       data_q;
   logic [2:0]        wait_cnt;
   logic [31:0]       periph_rdata;
   logic              periph_wr;
   logic              rd_last;

   wire unused_addr_lsb = &{1'b0, M_addr[1:0]};

   always_comb begin
      region_dec = REG_NONE;
      if (M_addr[31:RAM_AW+2] == '0)
         region_dec = REG_RAM;
      else if (M_addr[31:2] == LED_ADDR[31:2])
         region_dec = REG_LED;
      else if (M_addr[31:2] == SW_ADDR[31:2])
         region_dec = REG_SW;
      else if (M_addr[31:2] == CNT_ADDR[31:2])
         region_dec = REG_CNT;
   end

   // wait_cnt==0 is the enable cycle; data is valid RAM_LATENCY cycles later
   assign rd_last   = (state == ST_RAM_RD) && (wait_cnt == 3'(RAM_LATENCY));
   assign periph_wr = (state == ST_PERIPH) && w_q;
   assign ram_addr  = addr_q;
   assign ram_din   = data_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      ram_en    = 1'b0;
      ram_we    = 1'b0;
      MIO_ready = 1'b0;
      case (state)
         ST_IDLE: begin
            MIO_ready = !mem_req;
            if (mem_req) begin
               if (region_dec == REG_RAM)
                  state_nx = mem_w ? ST_RAM_WR : ST_RAM_RD;
               else
                  state_nx = ST_PERIPH;
            end
         end
         ST_RAM_WR: begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            state_nx = ST_DONE;
         end
         ST_RAM_RD: begin
            ram_en = (wait_cnt == 3'd0);
            if (rd_last)
               state_nx = ST_DONE;
         end
         ST_PERIPH: state_nx = ST_DONE;
         ST_DONE: begin
            MIO_ready = 1'b1;
            state_nx  = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         region_q <= REG_NONE;
         w_q      <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         wait_cnt <= '0;
         data2CPU <= '0;
         bus_err  <= 1'b0;
      end else begin
         bus_err  <= (state == ST_PERIPH) && (region_q == REG_NONE);
         wait_cnt <= (state == ST_RAM_RD) ? wait_cnt + 3'd1 : 3'd0;
         if (state == ST_IDLE && mem_req) begin
            region_q <= region_dec;
            w_q      <= mem_w;
            addr_q   <= M_addr[RAM_AW+1:2];
            data_q   <= data_out;
         end
         if (rd_last)
            data2CPU <= ram_dout;
         else if (state == ST_PERIPH && !w_q)
            data2CPU <= periph_rdata;
      end
   end

   mio_periph_regs #(
      .SW_W (SW_W)
   ) u_periph (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (periph_wr),
      .sel     (region_q),
      .wdata   (data_q),
      .sw_in   (sw_in),
      .rdata   (periph_rdata),
      .led_out (led_out)
   );

endmodule

// File: tb/tb_mio_bus_responder.sv
// tb/tb_mio_bus_responder.sv - directed self-checking bench for mio_bus_responder (RAM_LATENCY=2)
module tb_mio_bus_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_req;
   logic        mem_w;
   logic [31:0] M_addr;
   logic [31:0] data_out;
   logic [31:0] data2CPU;
   logic        MIO_ready;
   logic        bus_err;
   logic        ram_en;
   logic        ram_we;
   logic [13:0] ram_addr;
   logic [31:0] ram_din;
   logic [31:0] ram_dout;
   logic [15:0] sw_in;
   logic [31:0] led_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mio_bus_responder dut (
      .clk       (clk),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_w     (mem_w),
      .M_addr    (M_addr),
      .data_out  (data_out),
      .data2CPU  (data2CPU),
      .MIO_ready (MIO_ready),
      .bus_err   (bus_err),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout),
      .sw_in     (sw_in),
      .led_out   (led_out)
   );

   // two-stage synchronous RAM: data valid two cycles after the enable cycle
   logic [31:0] mem [0:255];
   logic [31:0] rd_pipe;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      rd_pipe  = '0;
      ram_dout = '0;
   end

   always @(posedge clk) begin
      if (ram_en && ram_we) mem[ram_addr[7:0]] <= ram_din;
      if (ram_en) rd_pipe <= mem[ram_addr[7:0]];
      ram_dout <= rd_pipe;
   end

   int          en_cnt = 0;
   int          we_cnt = 0;
   logic [31:0] last_we_addr = '0;
   logic [31:0] last_we_din  = '0;

   always @(negedge clk) begin
      if (ram_en) en_cnt <= en_cnt + 1;
      if (ram_we) begin
         we_cnt       <= we_cnt + 1;
         last_we_addr <= 32'(ram_addr);
         last_we_din  <= ram_din;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic wait_done(input logic keep, output logic [31:0] rd, output int cyc, output logic err);
      cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         if (MIO_ready) break;
         if (cyc >= 20) begin
            check("done_timeout", {31'd0, MIO_ready}, 32'd1);
            break;
         end
      end
      rd  = data2CPU;
      err = bus_err;
      if (!keep) mem_req = 1'b0;
   endtask

   task automatic bus_access(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                             input logic keep, output logic [31:0] rd, output int cyc, output logic err);
      mem_req  = 1'b1;
      mem_w    = w;
      M_addr   = addr;
      data_out = wd;
      wait_done(keep, rd, cyc, err);
   endtask

   logic [31:0] rd;
   int          cyc;
   logic        err;
   int          e0, w0, rdy_seen;

   initial begin
      reset = 1'b0; mem_req = 1'b0; mem_w = 1'b0;
      M_addr = '0; data_out = '0; sw_in = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, MIO_ready}, 32'd1);
      check("rst_ram_en", {31'd0, ram_en}, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      check("idle_ready", {31'd0, MIO_ready}, 32'd1);
      check("idle_data", data2CPU, 32'h0);
      check("idle_led", led_out, 32'h0);
      check("idle_err", {31'd0, bus_err}, 32'd0);

      // RAM write then read back
      e0 = en_cnt; w0 = we_cnt;
      @(negedge clk); bus_access(1'b1, 32'h10, 32'hDEADBEEF, 1'b0, rd, cyc, err);
      check("wr_latency", cyc, 32'd2);
      check("wr_we_cycles", we_cnt - w0, 32'd1);
      check("wr_ram_addr", last_we_addr, 32'd4);
      check("wr_ram_din", last_we_din, 32'hDEADBEEF);
      check("wr_data_hold", data2CPU, 32'h0);
      e0 = en_cnt;
      @(negedge clk); bus_access(1'b0, 32'h10, 32'h0, 1'b0, rd, cyc, err);
      check("rd_latency", cyc, 32'd4);
      check("rd_data", rd, 32'hDEADBEEF);
      check("rd_en_cycles", en_cnt - e0, 32'd1);

      // LED and switches
      @(negedge clk); bus_access(1'b1, 32'hF000_0000, 32'h0000_00A5, 1'b0, rd, cyc, err);
      check("led_latency", cyc, 32'd2);
      check("led_value", led_out, 32'hA5);
      check("led_data_hold", rd, 32'hDEADBEEF);
      @(negedge clk); bus_access(1'b0, 32'hF000_0000, 32'h0, 1'b0, rd, cyc, err);
      check("led_readback", rd, 32'hA5);
      sw_in = 16'h1234;
      repeat (3) @(negedge clk);
      @(negedge clk); bus_access(1'b0, 32'hF000_0004, 32'h0, 1'b0, rd, cyc, err);
      check("sw_read", rd, 32'h0000_1234);
      @(negedge clk); bus_access(1'b1, 32'hF000_0004, 32'hFFFF_FFFF, 1'b0, rd, cyc, err);
      check("sw_write_no_err", {31'd0, err}, 32'd0);

      // counter load and wrap: load lands at the end of PERIPH, read PERIPH is two cycles later
      @(negedge clk); bus_access(1'b1, 32'hF000_0008, 32'hFFFF_FFFE, 1'b0, rd, cyc, err);
      @(negedge clk); bus_access(1'b0, 32'hF000_0008, 32'h0, 1'b0, rd, cyc, err);
      check("cnt_wrap0", rd, 32'h0000_0000);
      @(negedge clk); bus_access(1'b0, 32'hF000_0008, 32'h0, 1'b0, rd, cyc, err);
      check("cnt_wrap1", rd, 32'h0000_0003);

      // unmapped read and write
      @(negedge clk); bus_access(1'b0, 32'h8000_0000, 32'h0, 1'b0, rd, cyc, err);
      check("unm_rd_data", rd, 32'h0);
      check("unm_rd_err", {31'd0, err}, 32'd1);
      check("unm_rd_lat", cyc, 32'd2);
      @(negedge clk);
      check("unm_err_pulse", {31'd0, bus_err}, 32'd0);
      e0 = en_cnt;
      bus_access(1'b1, 32'h8000_0000, 32'h0000_0055, 1'b0, rd, cyc, err);
      check("unm_wr_err", {31'd0, err}, 32'd1);
      check("unm_wr_led", led_out, 32'hA5);
      check("unm_wr_ram", en_cnt - e0, 32'd0);

      // back-to-back RAM reads with mem_req held across DONE
      @(negedge clk); bus_access(1'b1, 32'h20, 32'h1111_1111, 1'b0, rd, cyc, err);
      e0 = en_cnt;
      @(negedge clk); bus_access(1'b0, 32'h10, 32'h0, 1'b1, rd, cyc, err);
      check("b2b_first", rd, 32'hDEADBEEF);
      check("b2b_first_lat", cyc, 32'd4);
      bus_access(1'b0, 32'h20, 32'h0, 1'b0, rd, cyc, err);
      check("b2b_second", rd, 32'h1111_1111);
      check("b2b_second_lat", cyc, 32'd5);
      check("b2b_en_cycles", en_cnt - e0, 32'd2);

      // reset in the middle of a RAM read
      @(negedge clk);
      mem_req = 1'b1; mem_w = 1'b0; M_addr = 32'h20;
      @(negedge clk);
      check("mid_rd_en", {31'd0, ram_en}, 32'd1);
      reset = 1'b0;
      #1;
      check("rst_en_drop", {31'd0, ram_en}, 32'd0);
      check("rst_no_ready", {31'd0, MIO_ready}, 32'd0);
      check("rst_data", data2CPU, 32'h0);
      rdy_seen = 0;
      repeat (2) begin
         @(negedge clk);
         if (MIO_ready) rdy_seen++;
      end
      check("rst_no_pulse", rdy_seen, 32'd0);
      reset = 1'b1;
      wait_done(1'b0, rd, cyc, err);
      check("post_rst_lat", cyc, 32'd4);
      check("post_rst_data", rd, 32'h1111_1111);

      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mio_bus_responder.md
Name: mio_bus_responder

Overview:
- Target-side memory/IO controller answering the multicycle CPU's memory requests.
- Accepts address, write data and read/write strobes from the CPU.
- Decodes the address to external synchronous RAM or internal peripheral registers (LED, switches, counter).
- Inserts wait states and returns read data together with MIO_ready, which gates PC and state advance in the CPU.

Parameters:
- RAM_AW, 14, RAM word-address width; RAM occupies byte addresses 0x0000_0000 .. (4<<RAM_AW)-1.
- RAM_LATENCY, 2, cycles from ram_en to valid ram_dout; legal range 1..7.
- SW_W, 16, switch input width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- mem_req  input  1  CPU request valid; held with addr/data until the MIO_ready completion cycle
- mem_w  input  1  1=write, 0=read; sampled with mem_req
- M_addr  input  32  byte address; bits [1:0] ignored
- data_out  input  32  CPU write data
- data2CPU  output  32  read data to CPU
- MIO_ready  output  1  transfer complete / bus idle
- bus_err  output  1  one-cycle pulse on unmapped access
- ram_en  output  1  RAM access enable
- ram_we  output  1  RAM write enable
- ram_addr  output  RAM_AW  RAM word address
- ram_din  output  32  RAM write data
- ram_dout  input  32  RAM read data
- sw_in  input  SW_W  asynchronous switches
- led_out  output  32  LED register

Behaviour:
- Reset (reset=0, async):
  - FSM to IDLE; data2CPU=0, led_out=0, counter=0.
  - ram_en=0, ram_we=0, bus_err=0; switch synchronizer flops cleared.
  - An access in flight when reset asserts is abandoned and no completion is signalled.
- Address map (M_addr[31:2] compare):
  - RAM: M_addr < 4<<RAM_AW.
  - 0xF000_0000 LED (R/W).
  - 0xF000_0004 switches (RO, zero-extended; writes ignored, no error).
  - 0xF000_0008 counter (R/W).
  - Anything else unmapped: reads return 0, writes are dropped, bus_err pulses in the DONE cycle.
- FSM states: IDLE, RAM_WR, RAM_RD, PERIPH, DONE.
  - IDLE, mem_req=0: stay.
  - IDLE, mem_req=1: latch addr, data, mem_w, region. Then RAM write -> RAM_WR, RAM read -> RAM_RD, peripheral or unmapped -> PERIPH.
  - RAM_WR: ram_en=ram_we=1 for exactly this one cycle; ram_addr and ram_din from latches; -> DONE.
  - RAM_RD: ram_en=1 on first cycle only; wait counter runs RAM_LATENCY cycles; on the last one capture ram_dout into data2CPU; -> DONE.
  - PERIPH: perform register write, or capture register value into data2CPU; -> DONE.
  - DONE: MIO_ready=1 for exactly one cycle; -> IDLE.
- MIO_ready = (state==IDLE && !mem_req) || state==DONE.
  - Combinational in mem_req, so non-memory CPU cycles see ready=1.
- Latency, request cycle to DONE: RAM write 2 cycles, peripheral 2 cycles, RAM read RAM_LATENCY+2 cycles.
- Back-to-back requests: mem_req high in the cycle after DONE (state IDLE) is a new request. No request is lost or duplicated.
- data2CPU holds its last read value across writes and idle cycles; it updates only when a read completes.
- Counter:
  - 32-bit, increments every cycle, wraps 0xFFFF_FFFF -> 0.
  - A CPU write in PERIPH loads data_out, and the write takes priority over that cycle's increment.
  - A read returns the value at the PERIPH cycle.
- Switches pass through a 2-flop synchronizer; reads see the value 2 cycles stale.
- Changes to mem_w or M_addr during a transfer are ignored because the latched copy is used.

Decomposition:
- Package mio_pkg: address-map constants (LED_ADDR, SW_ADDR, CNT_ADDR), region enum (REG_RAM, REG_LED, REG_SW, REG_CNT, REG_NONE), FSM state encoding.
- Sub-module mio_periph_regs: LED register, switch synchronizer and counter.
  - Inputs: write strobe, select, data.
  - Output: read mux.

Test Plan:
- Reset release with mem_req=0 -> MIO_ready=1, data2CPU=0, led_out=0. Reset mid-RAM_RD -> ram_en=0 immediately, no ready pulse, next request served normally.
- RAM write 0xDEADBEEF @0x0000_0010, then read @0x0000_0010 with RAM_LATENCY=2 -> ram_we one cycle with ram_addr=4; read completes 4 cycles after request with data2CPU=0xDEADBEEF and MIO_ready high exactly one cycle.
- Write 0x0000_00A5 to 0xF000_0000 -> led_out=0xA5 after 2 cycles. Set sw_in=0x1234, wait 3 cycles, read 0xF000_0004 -> data2CPU=0x0000_1234.
- Write 0xFFFF_FFFE to counter, read it back on consecutive requests -> values wrap through 0xFFFF_FFFF to small values; written value is not off by one.
- Read 0x8000_0000 -> data2CPU=0, bus_err one-cycle pulse aligned with MIO_ready. Write to the same address -> no RAM or LED change.
- Back-to-back RAM reads with mem_req held high across DONE -> two distinct completions, each with correct data, no extra ram_en.
